// File: rtl/ram_arb_pkg.sv
// Shared defaults and requester identifiers for the dual-port RAM arbiter.
// Holds the single tie-break rule that is used by both port selectors.
package ram_arb_pkg;

    localparam int DEF_ADDR_W   = 13;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_MAX_WAIT = 4;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_AUX = 1'b1
    } req_id_t;

    // The CPU wins a collision unless the aux requester has waited its limit.
    function automatic req_id_t pick_winner(input logic want0, input logic want1,
                                            input logic aux_prio);
        if (want1 && (!want0 || aux_prio))
            return REQ_AUX;
        return REQ_CPU;
    endfunction

endpackage

// File: rtl/ram_arb_port_sel.sv
// 2:1 selector for one RAM port: picks a winner and forwards its address.
// The enable, the address and the grants are all zero when blocked or idle.
module ram_arb_port_sel
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              block,
    input  logic              want0,
    input  logic              want1,
    input  logic              aux_prio,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              ce,
    output logic [ADDR_W-1:0] addr,
    output req_id_t           owner
);

    always_comb begin
        gnt0  = 1'b0;
        gnt1  = 1'b0;
        ce    = 1'b0;
        addr  = '0;
        owner = REQ_CPU;
        if (!block && (want0 || want1)) begin
            owner = pick_winner(want0, want1, aux_prio);
            ce    = 1'b1;
            if (owner == REQ_AUX) begin
                gnt1 = 1'b1;
                addr = addr1;
            end else begin
                gnt0 = 1'b1;
                addr = addr0;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a dual-port RAM (port A write, port B read).
// Each port is arbitrated independently; requester 1 gets an anti-starvation boost.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              cea,
    output logic [ADDR_W-1:0] ada,
    output logic [DATA_W-1:0] din,
    output logic              ceb,
    output logic [ADDR_W-1:0] adb,
    input  logic [DATA_W-1:0] dout
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_reg, wait_next;
    logic              rvalid_reg, rvalid_next;
    req_id_t           owner_reg, owner_next;
    logic              aux_prio;

    // Index 0 is the write port (A), index 1 the read port (B).
    logic [1:0]        want0, want1, sel_gnt0, sel_gnt1, sel_ce;
    logic [ADDR_W-1:0] sel_addr [2];
    req_id_t           sel_owner [2];

    assign aux_prio = (wait_reg == WAIT_MAX);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign want0[gi] = m0_req && (m0_we == (gi == 0));
            assign want1[gi] = m1_req && (m1_we == (gi == 0));

            ram_arb_port_sel #(
                .ADDR_W (ADDR_W)
            ) u_sel (
                .block    (rst),
                .want0    (want0[gi]),
                .want1    (want1[gi]),
                .aux_prio (aux_prio),
                .addr0    (m0_addr),
                .addr1    (m1_addr),
                .gnt0     (sel_gnt0[gi]),
                .gnt1     (sel_gnt1[gi]),
                .ce       (sel_ce[gi]),
                .addr     (sel_addr[gi]),
                .owner    (sel_owner[gi])
            );
        end
    endgenerate

    assign m0_gnt = |sel_gnt0;
    assign m1_gnt = |sel_gnt1;
    assign cea    = sel_ce[0];
    assign ada    = sel_addr[0];
    assign ceb    = sel_ce[1];
    assign adb    = sel_addr[1];

    always_comb begin
        din = '0;
        if (cea)
            din = (sel_owner[0] == REQ_AUX) ? m1_wdata : m0_wdata;
    end

    always_comb begin
        wait_next = wait_reg;
        if (!m1_req || m1_gnt)
            wait_next = '0;
        else if (wait_reg != WAIT_MAX)
            wait_next = wait_reg + 1'b1;
    end

    assign rvalid_next = ceb;
    assign owner_next  = sel_owner[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_reg   <= '0;
            rvalid_reg <= 1'b0;
            owner_reg  <= REQ_CPU;
        end else begin
            wait_reg   <= wait_next;
            rvalid_reg <= rvalid_next;
            owner_reg  <= owner_next;
        end
    end

    // Gated by rst so a read granted just before reset never reports data.
    assign m0_rvalid = rvalid_reg && !rst && (owner_reg == REQ_CPU);
    assign m1_rvalid = rvalid_reg && !rst && (owner_reg == REQ_AUX);
    assign m0_rdata  = dout;
    assign m1_rdata  = dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a simple read-first dual-port RAM model.
// Inputs change 1 ns after the rising edge; outputs are sampled 5 ns after it.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [12:0] m0_addr = '0, m1_addr = '0;
    logic [7:0]  m0_wdata = '0, m1_wdata = '0;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [7:0]  m0_rdata, m1_rdata;
    logic        cea, ceb;
    logic [12:0] ada, adb;
    logic [7:0]  din;
    logic [7:0]  dout = '0;
    logic [7:0]  mem [0:8191];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .cea(cea), .ada(ada), .din(din),
        .ceb(ceb), .adb(adb), .dout(dout)
    );

    always @(posedge clk) begin
        if (cea) mem[ada] <= din;
        if (ceb) dout <= mem[adb];
    end

    // Apply one cycle of inputs and advance to the sampling point.
    task automatic cyc(input logic r,
                       input logic q0, input logic w0, input logic [12:0] a0, input logic [7:0] d0,
                       input logic q1, input logic w1, input logic [12:0] a1, input logic [7:0] d1);
        @(posedge clk);
        #1;
        rst = r;
        m0_req = q0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = q1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
        #4;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 13'h0, 8'h00, 0, 0, 13'h0, 8'h00);
    endtask

    task automatic test_reset();
        cyc(1, 1, 1, 13'h0033, 8'h77, 1, 0, 13'h0044, 8'h00);
        checks++; if (m0_gnt !== 1'b0) begin errors++; $display("FAIL rst_m0_gnt: got %b want 0", m0_gnt); end
        checks++; if (m1_gnt !== 1'b0) begin errors++; $display("FAIL rst_m1_gnt: got %b want 0", m1_gnt); end
        checks++; if (cea !== 1'b0) begin errors++; $display("FAIL rst_cea: got %b want 0", cea); end
        checks++; if (ceb !== 1'b0) begin errors++; $display("FAIL rst_ceb: got %b want 0", ceb); end
        checks++; if (ada !== 13'h0) begin errors++; $display("FAIL rst_ada: got %h want 0", ada); end
        checks++; if (adb !== 13'h0) begin errors++; $display("FAIL rst_adb: got %h want 0", adb); end
        checks++; if (din !== 8'h0) begin errors++; $display("FAIL rst_din: got %h want 0", din); end
        checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_rvalid: got %b want 00", {m0_rvalid, m1_rvalid}); end
        $display("reset: gnt=%b%b cea=%b ceb=%b", m0_gnt, m1_gnt, cea, ceb);
        idle();
    endtask

    task automatic test_write_then_read();
        cyc(0, 1, 1, 13'h0010, 8'hA5, 0, 0, 13'h0, 8'h00);
        checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt: got %b want 1", m0_gnt); end
        checks++; if (cea !== 1'b1) begin errors++; $display("FAIL wr_cea: got %b want 1", cea); end
        checks++; if (ada !== 13'h0010) begin errors++; $display("FAIL wr_ada: got %h want 0010", ada); end
        checks++; if (din !== 8'hA5) begin errors++; $display("FAIL wr_din: got %h want a5", din); end
        checks++; if (ceb !== 1'b0) begin errors++; $display("FAIL wr_ceb: got %b want 0", ceb); end
        $display("write m0 0010<=a5: gnt=%b cea=%b ada=%h din=%h", m0_gnt, cea, ada, din);
        cyc(0, 0, 1, 13'h1FFF, 8'hFF, 1, 0, 13'h0010, 8'h00);
        checks++; if (m1_gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt: got %b want 1", m1_gnt); end
        checks++; if (m0_gnt !== 1'b0) begin errors++; $display("FAIL rd_m0_idle_gnt: got %b want 0", m0_gnt); end
        checks++; if (ceb !== 1'b1 || adb !== 13'h0010) begin errors++; $display("FAIL rd_port: got ceb=%b adb=%h want 1 0010", ceb, adb); end
        checks++; if (cea !== 1'b0 || ada !== 13'h0 || din !== 8'h0) begin errors++; $display("FAIL rd_wport_quiet: got cea=%b ada=%h din=%h want 0 0 0", cea, ada, din); end
        $display("read m1 0010: gnt=%b ceb=%b adb=%h", m1_gnt, ceb, adb);
        idle();
        checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== 8'hA5) begin errors++; $display("FAIL rd_data: got v=%b d=%h want 1 a5", m1_rvalid, m1_rdata); end
        checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL rd_m0_rvalid: got %b want 0", m0_rvalid); end
        $display("rvalid m1: v=%b d=%h", m1_rvalid, m1_rdata);
        idle();
        checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("FAIL rd_single_pulse: got %b want 0", m1_rvalid); end
    endtask

    task automatic test_parallel();
        cyc(0, 1, 1, 13'h0001, 8'h3C, 1, 0, 13'h0002, 8'h00);
        checks++; if ({m0_gnt, m1_gnt} !== 2'b11) begin errors++; $display("FAIL par_gnt: got %b want 11", {m0_gnt, m1_gnt}); end
        checks++; if ({cea, ceb} !== 2'b11) begin errors++; $display("FAIL par_ce: got %b want 11", {cea, ceb}); end
        checks++; if (ada !== 13'h0001 || adb !== 13'h0002 || din !== 8'h3C) begin errors++; $display("FAIL par_addr: got ada=%h adb=%h din=%h want 0001 0002 3c", ada, adb, din); end
        $display("parallel: gnt=%b%b cea=%b ceb=%b", m0_gnt, m1_gnt, cea, ceb);
        cyc(0, 0, 1, 13'h0123, 8'h99, 0, 0, 13'h0456, 8'h00);
        checks++; if ({m0_gnt, m1_gnt, cea, ceb} !== 4'b0000) begin errors++; $display("FAIL noreq_gate: got gnt=%b%b ce=%b%b want 0000", m0_gnt, m1_gnt, cea, ceb); end
        $display("no request: gnt=%b%b", m0_gnt, m1_gnt);
    endtask

    task automatic test_starvation();
        logic exp1;
        idle();
        for (int k = 1; k <= 10; k++) begin
            cyc(0, 1, 0, 13'h0010, 8'h00, 1, 0, 13'h0020, 8'h00);
            exp1 = (k % 5 == 0);
            checks++; if (m1_gnt !== exp1 || m0_gnt !== !exp1) begin errors++; $display("FAIL starve_gnt%0d: got %b%b want %b%b", k, m0_gnt, m1_gnt, !exp1, exp1); end
            checks++; if (adb !== (exp1 ? 13'h0020 : 13'h0010)) begin errors++; $display("FAIL starve_adb%0d: got %h want %h", k, adb, exp1 ? 13'h0020 : 13'h0010); end
            if (k > 1) begin
                checks++; if (m1_rvalid !== ((k - 1) % 5 == 0)) begin errors++; $display("FAIL starve_rvalid%0d: got %b want %b", k, m1_rvalid, (k - 1) % 5 == 0); end
            end
            $display("contend cycle %0d: gnt=%b%b adb=%h", k, m0_gnt, m1_gnt, adb);
        end
        idle();
        checks++; if (m1_rvalid !== 1'b1 || m0_rvalid !== 1'b0) begin errors++; $display("FAIL starve_last_rvalid: got %b%b want 01", m0_rvalid, m1_rvalid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d [3];
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 13'h0100 + 13'(i), exp_d[i], 0, 0, 13'h0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                cyc(0, 1, 0, 13'h0100 + 13'(i), 8'h00, 0, 0, 13'h0, 8'h00);
                checks++; if (m0_gnt !== 1'b1 || adb !== 13'h0100 + 13'(i)) begin errors++; $display("FAIL b2b_gnt%0d: got gnt=%b adb=%h want 1 %h", i, m0_gnt, adb, 13'h0100 + 13'(i)); end
            end else begin
                idle();
            end
            if (i >= 1 && i <= 3) begin
                checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== exp_d[i-1]) begin errors++; $display("FAIL b2b_data%0d: got v=%b d=%h want 1 %h", i - 1, m0_rvalid, m0_rdata, exp_d[i-1]); end
            end else begin
                checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_novalid%0d: got %b want 0", i, m0_rvalid); end
            end
            checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_m1_rvalid%0d: got %b want 0", i, m1_rvalid); end
            $display("b2b cycle %0d: gnt=%b rvalid=%b rdata=%h", i, m0_gnt, m0_rvalid, m0_rdata);
        end
    endtask

    task automatic test_reset_after_grant();
        idle();
        for (int k = 1; k <= 3; k++) begin
            cyc(0, 1, 0, 13'h0100, 8'h00, 1, 0, 13'h0101, 8'h00);
            checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL prerst_gnt%0d: got %b want 1", k, m0_gnt); end
        end
        cyc(1, 1, 0, 13'h0100, 8'h00, 1, 0, 13'h0101, 8'h00);
        checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_kill_rvalid: got %b%b want 00", m0_rvalid, m1_rvalid); end
        checks++; if ({m0_gnt, m1_gnt, cea, ceb} !== 4'b0000) begin errors++; $display("FAIL rst_quiet: got gnt=%b%b ce=%b%b want 0000", m0_gnt, m1_gnt, cea, ceb); end
        $display("reset after grant: rvalid=%b%b gnt=%b%b", m0_rvalid, m1_rvalid, m0_gnt, m1_gnt);
        for (int k = 1; k <= 5; k++) begin
            cyc(0, 1, 0, 13'h0100, 8'h00, 1, 0, 13'h0101, 8'h00);
            checks++; if (m1_gnt !== (k == 5) || m0_gnt !== (k != 5)) begin errors++; $display("FAIL postrst_gnt%0d: got %b%b want %b%b", k, m0_gnt, m1_gnt, k != 5, k == 5); end
            $display("post-reset cycle %0d: gnt=%b%b", k, m0_gnt, m1_gnt);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_write_then_read();
        test_parallel();
        test_starvation();
        test_back_to_back();
        test_reset_after_grant();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 13, RAM address width; DATA_W, default 8, RAM data width; MAX_WAIT, default 4, requester-1 starvation limit in cycles.
REQ-002 Ports SHALL be:
  clk  in  1  single clock, rising edge; one clock; reset is synchronous and active-high
  rst  in  1  synchronous active-high reset
  m0_req, m1_req  in  1  access request, held until granted
  m0_we, m1_we  in  1  1 = write (RAM port A), 0 = read (RAM port B)
  m0_addr, m1_addr  in  ADDR_W  access address
  m0_wdata, m1_wdata  in  DATA_W  write data
  m0_gnt, m1_gnt  out  1  access accepted this cycle (combinational)
  m0_rvalid, m1_rvalid  out  1  read data valid for this requester
  m0_rdata, m1_rdata  out  DATA_W  read data, both driven from dout
  cea  out  1  RAM write-port enable
  ada  out  ADDR_W  RAM write address
  din  out  DATA_W  RAM write data
  ceb  out  1  RAM read-port enable
  adb  out  ADDR_W  RAM read address
  dout  in  DATA_W  RAM read data, valid the cycle after a ceb cycle

Function
REQ-003 Requester 0 (CPU) and requester 1 (DMA/video) SHALL share the dual-port RAM; write port A and read port B SHALL be arbitrated independently each cycle.
REQ-004 Requesters wanting different ports in the same cycle SHALL both be granted in that cycle.
REQ-005 When both want the same port, requester 0 SHALL win unless the wait counter equals MAX_WAIT, in which case requester 1 SHALL win.
REQ-006 The wait counter SHALL increment each cycle m1_req=1 and m1_gnt=0, saturate at MAX_WAIT, and clear in any cycle m1_gnt=1 or m1_req=0.
REQ-007 A granted write SHALL drive cea=1, ada=addr and din=wdata in the grant cycle. A granted read SHALL drive ceb=1 and adb=addr in the grant cycle.
REQ-008 Non-granted ports SHALL drive their enable to 0 and their address and data to 0.
REQ-009 A registered read-owner tag SHALL make mX_rvalid=1 for exactly one cycle, the cycle after the read grant; mX_rdata SHALL equal dout in that cycle.
REQ-010 Back-to-back reads SHALL be supported: one read grant per cycle and one rvalid per cycle, in issue order.
REQ-011 A same-cycle write and read to the same address SHALL pass through unmodified; the RAM's read-during-write behaviour applies.
REQ-012 A request with mX_req=0 SHALL never be granted, whatever the state of we, addr or wdata.

Reset
REQ-013 While rst=1: gnt, cea and ceb SHALL be 0; ada, adb and din SHALL be 0; the wait counter and the owner tag SHALL clear.
REQ-014 rvalid SHALL be 0 in the cycle after rst is asserted, even if a read was granted in the cycle before reset.
REQ-015 Arbitration SHALL resume in the first cycle with rst=0.

Structure
REQ-016 Package ram_arb_pkg SHALL hold ADDR_W, DATA_W, MAX_WAIT defaults and the requester-ID typedef (REQ_CPU=0, REQ_AUX=1).
REQ-017 One sub-module, ram_arb_port_sel, SHALL perform the per-port 2:1 select. It SHALL be instantiated twice, once for write and once for read. The wait counter and owner tag SHALL reside in ram_arbiter.

Verification
REQ-018 m0 write addr 0x0010 data 0xA5, then m1 read 0x0010 -> cea=1, ada=0x0010, din=0xA5; read granted; m1_rvalid=1 with m1_rdata=0xA5 one cycle after the read grant.
REQ-019 Same cycle, m0 write 0x0001 and m1 read 0x0002 -> both gnt=1, cea=1, ceb=1.
REQ-020 m0 and m1 both read continuously, MAX_WAIT=4 -> m1 granted on the 5th cycle; m0 granted the other cycles; m1 is never blocked for more than 4 consecutive cycles.
REQ-021 m0 reads 0x0100, 0x0101, 0x0102 back-to-back -> three consecutive m0_rvalid pulses carrying those addresses' data in order; m1_rvalid stays 0.
REQ-022 rst asserted in the cycle after a read grant -> no rvalid; gnt, cea and ceb are 0 during reset; the wait counter is 0 afterwards.
